// File: rtl/lpc_sniffer_pkg.sv
// Shared definitions for the LPC sniffer: record layout, frame sync values
// and the framer state encoding.
package lpc_sniffer_pkg;

    localparam int unsigned REC_W        = 48;
    localparam int unsigned REC_CYC_MSB  = 47;
    localparam int unsigned REC_CYC_LSB  = 44;
    localparam int unsigned REC_DIR      = 43;
    localparam int unsigned REC_ADDR_MSB = 39;
    localparam int unsigned REC_ADDR_LSB = 8;
    localparam int unsigned REC_DATA_MSB = 7;
    localparam int unsigned REC_DATA_LSB = 0;

    localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'hA5;
    localparam logic [7:0] SYNC_DROP_BYTE_DEFAULT = 8'hA6;

    // Index of the last byte in a frame (sync byte + 6 record bytes).
    localparam logic [2:0] LAST_BYTE_IDX = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT_BUSY,
        WAIT_READY
    } framer_state_e;

endpackage

// File: rtl/record_fifo.sv
// Synchronous FIFO with extra-bit pointers; the parent decides what to do
// with writes that arrive while full.
module record_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q[AW-1:0]];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/lpc_record_framer.sv
// Buffers 48-bit LPC records and ships each one to the UART transmitter as a
// 7-byte frame (sync + 6 record bytes, MSB first) over a ready/strobe handshake.
module lpc_record_framer
    import lpc_sniffer_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter logic [7:0]  SYNC_DROP_BYTE = SYNC_DROP_BYTE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REC_W-1:0] rec_data,
    input  logic             rec_valid,
    output logic             fifo_full,
    output logic [7:0]       uart_data,
    output logic             uart_strobe,
    input  logic             uart_ready,
    output logic             busy,
    output logic [7:0]       drop_count
);

    localparam int unsigned CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    framer_state_e    state_q, state_d;
    logic             rdy_meta_q, rdy_s_q;
    logic [REC_W-1:0] shreg_q, shreg_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic             sync_drop_q, sync_drop_d;
    logic [CNT_W-1:0] strobe_cnt_q, strobe_cnt_d;
    logic             drop_pending_q, drop_pending_d;
    logic [7:0]       drop_count_q, drop_count_d;
    logic [7:0]       uart_data_q, uart_data_d;
    logic             uart_strobe_q;
    logic             pop, push, drop, fifo_empty;
    logic [REC_W-1:0] head;
    logic [7:0]       next_byte;

    record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (rec_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign push = rec_valid & (~fifo_full | pop);
    assign drop = rec_valid & fifo_full & ~pop;

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        shreg_d      = shreg_q;
        byte_idx_d   = byte_idx_q;
        sync_drop_d  = sync_drop_q;
        strobe_cnt_d = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && rdy_s_q) begin
                    pop         = 1'b1;
                    shreg_d     = head;
                    byte_idx_d  = 3'd0;
                    sync_drop_d = drop_pending_q;
                    state_d     = SETUP;
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                if (strobe_cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                    state_d = WAIT_BUSY;
                end else begin
                    strobe_cnt_d = strobe_cnt_q + 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (!rdy_s_q) state_d = WAIT_READY;
            end
            WAIT_READY: begin
                if (rdy_s_q) begin
                    if (byte_idx_q == LAST_BYTE_IDX) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        // The sync byte does not consume record bits.
                        if (byte_idx_q != 3'd0) shreg_d = {shreg_q[REC_W-9:0], 8'h00};
                        state_d = SETUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_pending_d = drop_pending_q;
        if (pop)  drop_pending_d = 1'b0;
        if (drop) drop_pending_d = 1'b1;

        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;

        if (byte_idx_d == 3'd0) begin
            next_byte = sync_drop_d ? SYNC_DROP_BYTE : SYNC_BYTE;
        end else begin
            next_byte = shreg_d[REC_W-1 -: 8];
        end
        uart_data_d = (state_d == SETUP) ? next_byte : uart_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rdy_meta_q     <= 1'b0;
            rdy_s_q        <= 1'b0;
            shreg_q        <= '0;
            byte_idx_q     <= 3'd0;
            sync_drop_q    <= 1'b0;
            strobe_cnt_q   <= '0;
            drop_pending_q <= 1'b0;
            drop_count_q   <= 8'd0;
            uart_data_q    <= 8'd0;
            uart_strobe_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rdy_meta_q     <= uart_ready;
            rdy_s_q        <= rdy_meta_q;
            shreg_q        <= shreg_d;
            byte_idx_q     <= byte_idx_d;
            sync_drop_q    <= sync_drop_d;
            strobe_cnt_q   <= strobe_cnt_d;
            drop_pending_q <= drop_pending_d;
            drop_count_q   <= drop_count_d;
            uart_data_q    <= uart_data_d;
            uart_strobe_q  <= (state_d == STROBE);
        end
    end

    assign uart_data   = uart_data_q;
    assign uart_strobe = uart_strobe_q;
    assign drop_count  = drop_count_q;
    assign busy        = (state_q != IDLE) | ~fifo_empty;

endmodule
